// File: rtl/spell_pkg.sv
// Shared constants and types for the spell memory arbiter: memory type codes,
// grant encodings and the arbiter state enum.
package spell_pkg;

   localparam logic [1:0] MemoryTypeCode = 2'b00;
   localparam logic [1:0] MemoryTypeData = 2'b01;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_CORE = 2'b01;
   localparam logic [1:0] GRANT_HOST = 2'b10;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_ACCESS = 2'b01,
      ARB_GAP    = 2'b10
   } arb_state_t;

endpackage

// File: rtl/spell_arb_watchdog.sv
// Access watchdog: counts enabled cycles from zero and flags expiry when the
// count reaches the limit; clear returns the count to zero.
module spell_arb_watchdog (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] limit,
   output logic       expired
);

   logic [7:0] count_r;

   // Cycle counter, parked at the limit so it never wraps
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= 8'h00;
      end else if (clear) begin
         count_r <= 8'h00;
      end else if (enable && !expired) begin
         count_r <= count_r + 8'h01;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = enable && (count_r == limit);

endmodule

// File: rtl/spell_mem_arbiter.sv
// Two-requester arbiter (spell core / host loader) in front of spell_mem_dff.
// Define SPELL_MEM_ARB_RR_EN for round-robin tie resolution; otherwise the host wins ties.
module spell_mem_arbiter
   import spell_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int GAP_CYCLES     = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       core_select,
   input  logic [7:0] core_addr,
   input  logic [7:0] core_wdata,
   input  logic [1:0] core_type,
   input  logic       core_write,
   output logic       core_ready,
   input  logic       host_select,
   input  logic [7:0] host_addr,
   input  logic [7:0] host_wdata,
   input  logic [1:0] host_type,
   input  logic       host_write,
   output logic       host_ready,
   output logic [7:0] rd_data,
   output logic [1:0] grant,
   output logic       err_timeout,
   output logic       mem_select,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic [1:0] mem_type,
   output logic       mem_write,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ready
);

   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES - 1);

   arb_state_t state_r, state_s;
   logic [1:0] gap_cnt_r, gap_cnt_s;
   logic       host_win_s, wd_expired_s, in_access_s;
   logic       mem_select_s, mem_write_s, core_ready_s, host_ready_s, err_timeout_s;
   logic [7:0] mem_addr_s, mem_wdata_s, rd_data_s;
   logic [1:0] mem_type_s, grant_s;
`ifdef SPELL_MEM_ARB_RR_EN
   logic       rr_host_r, rr_host_s;
`endif

   assign in_access_s = (state_r == ARB_ACCESS);

   spell_arb_watchdog u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (!in_access_s),
      .enable  (in_access_s),
      .limit   (WD_LIMIT),
      .expired (wd_expired_s)
   );

   // Winner selection; a lone requester always wins
   always_comb begin
      host_win_s = host_select;
`ifdef SPELL_MEM_ARB_RR_EN
      if (host_select && core_select) begin
         host_win_s = !rr_host_r;
      end else begin
         host_win_s = host_select;
      end
`endif
   end

   // Next-state and next-output logic
   always_comb begin
      state_s       = state_r;
      gap_cnt_s     = gap_cnt_r;
      mem_select_s  = mem_select;
      mem_addr_s    = mem_addr;
      mem_wdata_s   = mem_wdata;
      mem_type_s    = mem_type;
      mem_write_s   = mem_write;
      core_ready_s  = 1'b0;
      host_ready_s  = 1'b0;
      rd_data_s     = rd_data;
      grant_s       = grant;
      err_timeout_s = err_timeout;
`ifdef SPELL_MEM_ARB_RR_EN
      rr_host_s     = rr_host_r;
`endif
      case (state_r)
         ARB_IDLE: begin
            if (host_select || core_select) begin
               state_s      = ARB_ACCESS;
               mem_select_s = 1'b1;
               if (host_win_s) begin
                  mem_addr_s  = host_addr;
                  mem_wdata_s = host_wdata;
                  mem_type_s  = host_type;
                  mem_write_s = host_write;
                  grant_s     = GRANT_HOST;
               end else begin
                  mem_addr_s  = core_addr;
                  mem_wdata_s = core_wdata;
                  mem_type_s  = core_type;
                  mem_write_s = core_write;
                  grant_s     = GRANT_CORE;
               end
`ifdef SPELL_MEM_ARB_RR_EN
               rr_host_s = host_win_s;
`endif
            end else begin
               state_s = ARB_IDLE;
            end
         end
         ARB_ACCESS: begin
            // mem_ready beats the watchdog when both land on the same cycle
            if (mem_ready || wd_expired_s) begin
               state_s      = ARB_GAP;
               gap_cnt_s    = GAP_LOAD;
               mem_select_s = 1'b0;
               mem_write_s  = 1'b0;
               core_ready_s = grant[0];
               host_ready_s = grant[1];
               if (mem_ready) begin
                  rd_data_s = mem_rdata;
               end else begin
                  rd_data_s     = 8'h00;
                  err_timeout_s = 1'b1;
               end
            end else begin
               state_s = ARB_ACCESS;
            end
         end
         ARB_GAP: begin
            if (gap_cnt_r == 2'd0) begin
               state_s = ARB_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r - 2'd1;
            end
         end
         default: begin
            state_s      = ARB_IDLE;
            mem_select_s = 1'b0;
            mem_write_s  = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= ARB_IDLE;
         gap_cnt_r   <= 2'd0;
         mem_select  <= 1'b0;
         mem_addr    <= 8'h00;
         mem_wdata   <= 8'h00;
         mem_type    <= 2'b00;
         mem_write   <= 1'b0;
         core_ready  <= 1'b0;
         host_ready  <= 1'b0;
         rd_data     <= 8'h00;
         grant       <= GRANT_NONE;
         err_timeout <= 1'b0;
`ifdef SPELL_MEM_ARB_RR_EN
         rr_host_r   <= 1'b1;
`endif
      end else begin
         state_r     <= state_s;
         gap_cnt_r   <= gap_cnt_s;
         mem_select  <= mem_select_s;
         mem_addr    <= mem_addr_s;
         mem_wdata   <= mem_wdata_s;
         mem_type    <= mem_type_s;
         mem_write   <= mem_write_s;
         core_ready  <= core_ready_s;
         host_ready  <= host_ready_s;
         rd_data     <= rd_data_s;
         grant       <= grant_s;
         err_timeout <= err_timeout_s;
`ifdef SPELL_MEM_ARB_RR_EN
         rr_host_r   <= rr_host_s;
`endif
      end
   end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Randomized bench for spell_mem_arbiter: acts as both requesters and as the memory,
// predicting each transaction from a transaction-level model of the arbitration rules.
module tb_spell_mem_arbiter;
   import spell_pkg::*;

   localparam int TO  = 8;
   localparam int GAP = 1;

   logic       clock = 1'b0;
   logic       reset;
   logic       core_select, core_write, core_ready;
   logic [7:0] core_addr, core_wdata;
   logic [1:0] core_type;
   logic       host_select, host_write, host_ready;
   logic [7:0] host_addr, host_wdata;
   logic [1:0] host_type;
   logic [7:0] rd_data, mem_addr, mem_wdata, mem_rdata;
   logic [1:0] grant, mem_type;
   logic       err_timeout, mem_select, mem_write, mem_ready;

   int  errors = 0;
   int  checks = 0;
   bit  last_host = 1'b1;
   bit  err_exp = 1'b0;

   spell_mem_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
      .clock(clock), .reset(reset),
      .core_select(core_select), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_type(core_type), .core_write(core_write), .core_ready(core_ready),
      .host_select(host_select), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_type(host_type), .host_write(host_write), .host_ready(host_ready),
      .rd_data(rd_data), .grant(grant), .err_timeout(err_timeout),
      .mem_select(mem_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_type(mem_type), .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Tie winner under the configured policy: fixed host priority or alternate from last grantee.
   function automatic bit tie_host();
`ifdef SPELL_MEM_ARB_RR_EN
      return !last_host;
`else
      return 1'b1;
`endif
   endfunction

   // Serve one expected transaction as the memory; lat = cycle of mem_ready within ACCESS.
   task automatic serve(input bit exp_host, input logic [7:0] a, input logic [7:0] wd,
                        input logic [1:0] ty, input logic wr, input int lat,
                        input logic [7:0] rdat, input bit chained);
      int low;
      int cnt;
      bit seen;
      int exp_cnt;
      low  = chained ? 1 : 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (i == 0) check_eq("ready_pulse_width", {host_ready, core_ready}, 32'd0);
         if (mem_select) begin
            seen = 1'b1;
            break;
         end
         low++;
      end
      check_eq("grant_seen", seen, 32'd1);
      if (!seen) return;
      if (chained) check_eq("gap_cycles", low, GAP + 1);
      check_eq("grant", grant, exp_host ? GRANT_HOST : GRANT_CORE);
      last_host = exp_host;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (!mem_select) break;
         cnt++;
         check_eq("frozen_fields", {host_ready, core_ready, mem_write, mem_type, mem_wdata, mem_addr},
                  {2'b00, wr, ty, wd, a});
         if (cnt == 1) begin
            if (exp_host) begin
               host_addr = 8'($urandom); host_wdata = 8'($urandom); host_write = ~host_write;
            end else begin
               core_addr = 8'($urandom); core_wdata = 8'($urandom); core_write = ~core_write;
            end
         end
         if (cnt == lat) begin
            mem_ready = 1'b1;
            mem_rdata = rdat;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
         end
         @(negedge clock);
      end
      mem_ready = 1'b0;
      exp_cnt = (lat <= TO) ? lat : TO;
      if (lat > TO) err_exp = 1'b1;
      check_eq("access_cycles", cnt, exp_cnt);
      check_eq("ready_side", {host_ready, core_ready}, exp_host ? 32'd2 : 32'd1);
      check_eq("rd_data", rd_data, (lat <= TO) ? {24'd0, rdat} : 32'd0);
      check_eq("err_timeout", err_timeout, err_exp);
      if (exp_host) host_select = 1'b0;
      else          core_select = 1'b0;
   endtask

   initial begin
      logic [7:0] ca, cw, ha, hw, cr, hr;
      logic [1:0] ct, ht, req;
      logic       cwr, hwr;
      int         cl, hl;
      bit         first_host, seen;

      reset = 1'b1; mem_ready = 1'b0; mem_rdata = 8'h00;
      core_select = 1'b0; core_addr = 8'h00; core_wdata = 8'h00; core_type = 2'b00; core_write = 1'b0;
      host_select = 1'b0; host_addr = 8'h00; host_wdata = 8'h00; host_type = 2'b00; host_write = 1'b0;
      repeat (3) @(negedge clock);
      check_eq("reset_mem", {mem_select, mem_write, mem_type, mem_wdata, mem_addr}, 32'd0);
      check_eq("reset_status", {core_ready, host_ready, grant, err_timeout, rd_data}, 32'd0);
      reset = 1'b0;

      // Core read, ready after 3 cycles
      core_addr = 8'h10; core_wdata = 8'h00; core_type = MemoryTypeData; core_write = 1'b0;
      core_select = 1'b1;
      serve(1'b0, 8'h10, 8'h00, MemoryTypeData, 1'b0, 3, 8'hA5, 1'b0);

      // Host write that never gets mem_ready: watchdog abort
      host_addr = 8'h20; host_wdata = 8'h3C; host_type = MemoryTypeCode; host_write = 1'b1;
      host_select = 1'b1;
      serve(1'b1, 8'h20, 8'h3C, MemoryTypeCode, 1'b1, 100, 8'h77, 1'b0);

      for (int r = 0; r < 40; r++) begin
         req = (r < 3) ? 2'b11 : 2'($urandom_range(1, 3));
         ca = 8'($urandom); cw = 8'($urandom); ct = 2'($urandom); cwr = 1'($urandom);
         ha = 8'($urandom); hw = 8'($urandom); ht = 2'($urandom); hwr = 1'($urandom);
         cr = 8'($urandom); hr = 8'($urandom);
         cl = $urandom_range(1, 10); hl = $urandom_range(1, 10);
         core_addr = ca; core_wdata = cw; core_type = ct; core_write = cwr;
         host_addr = ha; host_wdata = hw; host_type = ht; host_write = hwr;
         core_select = req[0]; host_select = req[1];
         first_host = (req == 2'b11) ? tie_host() : req[1];
         if (first_host) serve(1'b1, ha, hw, ht, hwr, hl, hr, 1'b0);
         else            serve(1'b0, ca, cw, ct, cwr, cl, cr, 1'b0);
         if (req == 2'b11) begin
            if (first_host) serve(1'b0, ca, cw, ct, cwr, cl, cr, 1'b1);
            else            serve(1'b1, ha, hw, ht, hwr, hl, hr, 1'b1);
         end
      end

      // Reset during the second ACCESS cycle
      core_addr = 8'h44; core_select = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (mem_select) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq("reset_test_grant_seen", seen, 32'd1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("midreset_outputs", {mem_select, core_ready, host_ready, grant, err_timeout}, 32'd0);
      check_eq("midreset_rd_data", rd_data, 32'd0);
      reset = 1'b0; core_select = 1'b0;
      last_host = 1'b1; err_exp = 1'b0;

      // Tie right after reset exercises the post-reset tie policy
      core_addr = 8'h55; core_wdata = 8'h66; core_type = MemoryTypeCode; core_write = 1'b0;
      host_addr = 8'h77; host_wdata = 8'h88; host_type = MemoryTypeData; host_write = 1'b1;
      core_select = 1'b1; host_select = 1'b1;
      first_host = tie_host();
      if (first_host) begin
         serve(1'b1, 8'h77, 8'h88, MemoryTypeData, 1'b1, 2, 8'h12, 1'b0);
         serve(1'b0, 8'h55, 8'h66, MemoryTypeCode, 1'b0, 4, 8'h34, 1'b1);
      end else begin
         serve(1'b0, 8'h55, 8'h66, MemoryTypeCode, 1'b0, 4, 8'h34, 1'b0);
         serve(1'b1, 8'h77, 8'h88, MemoryTypeData, 1'b1, 2, 8'h12, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
